rect_buffer: RTL and testbench

- Double-buffered rectangle register file between the rect copy controller and the GPU rasterizer.
- Captures the 16-bit word stream the copy controller produces from data memory into a back bank, grouped as fixed 5-word rectangle records.
- On a frame swap, promotes the back bank to the front, where the rasterizer reads it by rectangle index with one-cycle latency.

---
 rtl/rect_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_rect_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rect_buffer.sv
// rect_buffer: double-buffered rectangle register file fed by the copy controller, read by the rasterizer.
// Optional edge precalculation (x2/y2) enabled by defining RECT_BUFFER_EDGE_PRECALC_EN.
`default_nettype none

module rect_buffer #(
    parameter int RECT_COUNT  = 64,
    parameter int INDEX_WIDTH = 6,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   copy_start,
    input  logic                   wr_valid,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   frame_swap,
    input  logic                   rd_en,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic [DATA_WIDTH-1:0]  rd_x,
    output logic [DATA_WIDTH-1:0]  rd_y,
    output logic [DATA_WIDTH-1:0]  rd_w,
    output logic [DATA_WIDTH-1:0]  rd_h,
    output logic [DATA_WIDTH-1:0]  rd_color,
    output logic                   rd_valid,
    output logic [DATA_WIDTH-1:0]  rd_x2,
    output logic [DATA_WIDTH-1:0]  rd_y2,
    output logic                   load_done,
    output logic                   swap_miss,
    output logic                   overflow
);

    localparam int DEPTH = 2 * RECT_COUNT;
    localparam logic [INDEX_WIDTH-1:0] LAST_RECT = INDEX_WIDTH'(RECT_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             field_cnt_q, field_cnt_d;
    logic [INDEX_WIDTH-1:0] rect_cnt_q, rect_cnt_d;
    logic                   front_sel_q, front_sel_d;
    logic                   swap_miss_q, swap_miss_d;
    logic                   overflow_q, overflow_d;
    logic                   load_done_q;

    logic                   swap_ok;
    logic                   wr_en;
    logic                   wr_last;
    logic [2:0]             wr_field;
    logic [INDEX_WIDTH-1:0] wr_rect;
    logic [INDEX_WIDTH:0]   wr_addr;
    logic [INDEX_WIDTH:0]   rd_addr;

    logic [DATA_WIDTH-1:0] x_mem [DEPTH];
    logic [DATA_WIDTH-1:0] y_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_mem [DEPTH];
    logic [DATA_WIDTH-1:0] h_mem [DEPTH];
    logic [DATA_WIDTH-1:0] c_mem [DEPTH];

    logic [DATA_WIDTH-1:0] rd_x_q, rd_y_q, rd_w_q, rd_h_q, rd_color_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            field_cnt_q <= '0;
            rect_cnt_q  <= '0;
            front_sel_q <= 1'b0;
            swap_miss_q <= 1'b0;
            overflow_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_cnt_q <= field_cnt_d;
            rect_cnt_q  <= rect_cnt_d;
            front_sel_q <= front_sel_d;
            swap_miss_q <= swap_miss_d;
            overflow_q  <= overflow_d;
            load_done_q <= (state_d == S_DONE);
        end
    end

    // The swap is resolved against the current state before copy_start, so a
    // simultaneous start loads into the bank that has just become the back.
    always_comb begin
        state_d     = state_q;
        field_cnt_d = field_cnt_q;
        rect_cnt_d  = rect_cnt_q;
        front_sel_d = front_sel_q;
        swap_miss_d = swap_miss_q;
        overflow_d  = overflow_q;

        swap_ok  = frame_swap && (state_q == S_DONE);
        wr_field = copy_start ? 3'd0 : field_cnt_q;
        wr_rect  = copy_start ? '0 : rect_cnt_q;
        wr_en    = wr_valid && (copy_start || (state_q == S_LOAD));
        wr_last  = (wr_field == 3'd4) && (wr_rect == LAST_RECT);

        if (frame_swap && !swap_ok) begin
            swap_miss_d = 1'b1;
        end
        if (swap_ok) begin
            front_sel_d = ~front_sel_q;
            state_d     = S_IDLE;
        end
        if (wr_valid && !copy_start && (state_q == S_DONE)) begin
            overflow_d = 1'b1;
        end
        if (copy_start) begin
            state_d     = S_LOAD;
            field_cnt_d = '0;
            rect_cnt_d  = '0;
        end
        if (wr_en) begin
            if (wr_field == 3'd4) begin
                field_cnt_d = '0;
                rect_cnt_d  = wr_rect + 1'b1;
            end else begin
                field_cnt_d = wr_field + 3'd1;
            end
            if (wr_last) begin
                state_d = S_DONE;
            end
        end

        wr_addr = {~front_sel_d, wr_rect};
        rd_addr = {front_sel_q, rd_index};
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (wr_field)
                3'd0:    x_mem[wr_addr] <= wr_data;
                3'd1:    y_mem[wr_addr] <= wr_data;
                3'd2:    w_mem[wr_addr] <= wr_data;
                3'd3:    h_mem[wr_addr] <= wr_data;
                default: c_mem[wr_addr] <= wr_data;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_w_q     <= '0;
            rd_h_q     <= '0;
            rd_color_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_x_q     <= x_mem[rd_addr];
                rd_y_q     <= y_mem[rd_addr];
                rd_w_q     <= w_mem[rd_addr];
                rd_h_q     <= h_mem[rd_addr];
                rd_color_q <= c_mem[rd_addr];
            end
        end
    end

`ifdef RECT_BUFFER_EDGE_PRECALC_EN
    logic [DATA_WIDTH-1:0] x_hold_q, y_hold_q;
    logic [DATA_WIDTH-1:0] rd_x2_q, rd_y2_q;
    logic [DATA_WIDTH-1:0] x2_mem [DEPTH];
    logic [DATA_WIDTH-1:0] y2_mem [DEPTH];

    // x and y always precede w and h within a record, so the held copies
    // belong to the rectangle currently being written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_hold_q <= '0;
            y_hold_q <= '0;
            rd_x2_q  <= '0;
            rd_y2_q  <= '0;
        end else begin
            if (wr_en && (wr_field == 3'd0)) x_hold_q <= wr_data;
            if (wr_en && (wr_field == 3'd1)) y_hold_q <= wr_data;
            if (rd_en) begin
                rd_x2_q <= x2_mem[rd_addr];
                rd_y2_q <= y2_mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && (wr_field == 3'd2)) x2_mem[wr_addr] <= x_hold_q + wr_data;
        if (wr_en && (wr_field == 3'd3)) y2_mem[wr_addr] <= y_hold_q + wr_data;
    end

    assign rd_x2 = rd_x2_q;
    assign rd_y2 = rd_y2_q;
`else
    assign rd_x2 = '0;
    assign rd_y2 = '0;
`endif

    assign rd_x      = rd_x_q;
    assign rd_y      = rd_y_q;
    assign rd_w      = rd_w_q;
    assign rd_h      = rd_h_q;
    assign rd_color  = rd_color_q;
    assign rd_valid  = rd_valid_q;
    assign load_done = load_done_q;
    assign swap_miss = swap_miss_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_rect_buffer.sv
// tb_rect_buffer: directed + randomized checks of rect_buffer against a bank-array reference model.
`default_nettype none

module tb_rect_buffer;

    localparam int RC = 64;
    localparam int IW = 6;
    localparam int DW = 16;
    localparam int NW = RC * 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          copy_start = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          frame_swap = 1'b0;
    logic          rd_en = 1'b0;
    logic [IW-1:0] rd_index = '0;
    logic [DW-1:0] rd_x, rd_y, rd_w, rd_h, rd_color, rd_x2, rd_y2;
    logic          rd_valid, load_done, swap_miss, overflow;

    rect_buffer #(.RECT_COUNT(RC), .INDEX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .copy_start(copy_start), .wr_valid(wr_valid),
        .wr_data(wr_data), .frame_swap(frame_swap), .rd_en(rd_en), .rd_index(rd_index),
        .rd_x(rd_x), .rd_y(rd_y), .rd_w(rd_w), .rd_h(rd_h), .rd_color(rd_color),
        .rd_valid(rd_valid), .rd_x2(rd_x2), .rd_y2(rd_y2), .load_done(load_done),
        .swap_miss(swap_miss), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: two banks of records, words addressed by running word count.
    logic [DW-1:0] bank    [2][RC][5];
    logic [DW-1:0] bank_x2 [2][RC];
    logic [DW-1:0] bank_y2 [2][RC];
    bit            bank_ok [2];
    int            front, mode, words;   // mode: 0 idle, 1 loading, 2 complete
    bit            m_miss, m_ovf;
    logic [DW-1:0] exp_rd [7];
    bit            exp_known, exp_valid;
    int            n_assert = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk("rd_valid", {15'd0, rd_valid}, {15'd0, exp_valid});
        chk("load_done", {15'd0, load_done}, {15'd0, mode == 2});
        chk("swap_miss", {15'd0, swap_miss}, {15'd0, m_miss});
        chk("overflow", {15'd0, overflow}, {15'd0, m_ovf});
        if (exp_known) begin
            chk("rd_x", rd_x, exp_rd[0]);
            chk("rd_y", rd_y, exp_rd[1]);
            chk("rd_w", rd_w, exp_rd[2]);
            chk("rd_h", rd_h, exp_rd[3]);
            chk("rd_color", rd_color, exp_rd[4]);
            chk("rd_x2", rd_x2, exp_rd[5]);
            chk("rd_y2", rd_y2, exp_rd[6]);
        end
    endtask

    task automatic do_reset();
        copy_start = 0; wr_valid = 0; frame_swap = 0; rd_en = 0;
        reset = 1'b1;
        #2;
        mode = 0; words = 0; front = 0; m_miss = 0; m_ovf = 0;
        bank_ok[0] = 0; bank_ok[1] = 0;
        for (int k = 0; k < 7; k++) exp_rd[k] = '0;
        exp_known = 1; exp_valid = 0;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic cyc(input bit cs, input bit wv, input logic [DW-1:0] wd,
                       input bit fs, input bit re, input int ri);
        int pre, back, r, f;
        copy_start = cs; wr_valid = wv; wr_data = wd; frame_swap = fs;
        rd_en = re; rd_index = ri[IW-1:0];
        @(posedge clk);
        pre = mode;
        exp_valid = re;
        if (re) begin
            exp_known = bank_ok[front];
            for (int k = 0; k < 5; k++) exp_rd[k] = bank[front][ri % RC][k];
`ifdef RECT_BUFFER_EDGE_PRECALC_EN
            exp_rd[5] = bank_x2[front][ri % RC];
            exp_rd[6] = bank_y2[front][ri % RC];
`else
            exp_rd[5] = '0;
            exp_rd[6] = '0;
`endif
        end
        if (fs) begin
            if (pre == 2) begin
                front = front ^ 1;
                bank_ok[front] = 1;
                mode = 0;
            end else begin
                m_miss = 1;
            end
        end
        back = front ^ 1;
        if (wv && !cs && pre == 2) m_ovf = 1;
        if (cs) begin
            mode = 1;
            words = 0;
        end
        if (wv && (cs || pre == 1)) begin
            r = words / 5;
            f = words % 5;
            bank[back][r][f] = wd;
            if (f == 2) bank_x2[back][r] = bank[back][r][0] + wd;
            if (f == 3) bank_y2[back][r] = bank[back][r][1] + wd;
            words++;
            if (words == NW) mode = 2;
        end
        #1;
        check_outputs();
    endtask

    logic [DW-1:0] wd, last_word;
    bit            cs_r, fs_r;

    initial begin
        #3;
        do_reset();

        // Reset in the middle of a load
        cyc(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, DW'(i), 0, 0, 0);
        #2;
        do_reset();

        // Frame 1: word value equals word index
        cyc(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < NW; i++) cyc(0, 1, DW'(i), 0, 0, 0);
        cyc(0, 0, '0, 1, 0, 0);
        cyc(0, 0, '0, 0, 1, 2);
        chk("f1_r2_x", rd_x, 16'd10);
        chk("f1_r2_y", rd_y, 16'd11);
        chk("f1_r2_w", rd_w, 16'd12);
        chk("f1_r2_h", rd_h, 16'd13);
        chk("f1_r2_color", rd_color, 16'd14);
        chk("f1_r2_valid", {15'd0, rd_valid}, 16'd1);
`ifdef RECT_BUFFER_EDGE_PRECALC_EN
        chk("f1_r2_x2", rd_x2, 16'd22);
        chk("f1_r2_y2", rd_y2, 16'd24);
`else
        chk("f1_r2_x2_tied", rd_x2, 16'd0);
`endif

        // Frame 2: early swap is refused, then overflow once complete
        cyc(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < NW; i++) begin
            wd = DW'($urandom);
            last_word = wd;
            cyc(0, 1, wd, i == 100, i == 101, 2);
            if (i == 101) begin
                chk("early_swap_miss", {15'd0, swap_miss}, 16'd1);
                chk("early_swap_front_x", rd_x, 16'd10);
                chk("early_swap_front_color", rd_color, 16'd14);
            end
        end
        chk("f2_load_done", {15'd0, load_done}, 16'd1);
        cyc(0, 1, DW'($urandom), 0, 0, 0);
        chk("f2_overflow", {15'd0, overflow}, 16'd1);
        cyc(0, 0, '0, 1, 0, 0);
        cyc(0, 0, '0, 0, 1, 63);
        chk("f2_r63_color", rd_color, last_word);

        // Frame 3: wrapping edge sum, then swap coinciding with a read
        cyc(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < NW; i++) begin
            wd = (i == 25) ? 16'hFFF0 : (i == 27) ? 16'h0020 : DW'($urandom);
            cyc(0, 1, wd, 0, 0, 0);
        end
        cyc(0, 0, '0, 1, 1, 5);
        cyc(0, 0, '0, 0, 1, 5);
        chk("f3_r5_x", rd_x, 16'hFFF0);
        chk("f3_r5_w", rd_w, 16'h0020);
`ifdef RECT_BUFFER_EDGE_PRECALC_EN
        chk("f3_r5_x2_wrap", rd_x2, 16'h0010);
`endif

        // Randomized traffic, including swap coinciding with copy_start
        for (int i = 0; i < 8000; i++) begin
            fs_r = ($urandom % 60) == 0;
            cs_r = (($urandom % 900) == 0) || (fs_r && mode == 2 && ($urandom % 2) == 1)
                   || (mode == 0 && ($urandom % 40) == 0);
            cyc(cs_r, ($urandom % 4) != 0, DW'($urandom), fs_r, ($urandom % 3) == 0,
                int'($urandom % RC));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
